// File: rtl/scanline_pkg.sv
// Shared types and geometry for the scanline ping-pong buffer.
//   color_t      : one 12-bit RGB pixel {r[3:0], g[3:0], b[3:0]}
//   fill_state_t : state of the renderer-facing fill bank
//   next_req_y() : line the renderer must produce after the vga shows line y
package scanline_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned COLOR_W  = 12;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  // The renderer works one line ahead of the raster, wrapping at the frame end.
  function automatic logic [9:0] next_req_y(input logic [9:0] y);
    logic [9:0] y_last;
    y_last = 10'(V_ACTIVE - 1);
    return (y == y_last) ? 10'd0 : y + 10'd1;
  endfunction

endpackage

// File: rtl/scanline_bank_ram.sv
// One line bank: Depth x Width, one synchronous write port and one synchronous
// read port, no reset so it maps onto block RAM.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read port; rdata_o valid the cycle after re_i
module scanline_bank_ram #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 12,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scanline_buffer.sv
// Ping-pong line buffer feeding the vga timing block's color_in.
// A renderer streams one line into the fill bank while the vga drains the
// display bank; the banks swap on next_line once the fill bank is complete.
// A next_line that finds the fill bank incomplete repeats the previous line
// and raises underrun for one cycle.
//   CLK25MHZ, ck_rst (async, active-low)
//   wr_valid/wr_ready/wr_data/wr_last : renderer pixel stream
//   req_y/req_stb                      : line the renderer must produce next
//   next_line/next_y/disp_en           : raster timing from the vga block
//   color_out                          : pixel, one cycle after disp_en
//   underrun                           : line not ready at next_line
// Build option SCANLINE_UNDERRUN_CNT_EN adds underrun_cnt (saturating, 16 bit).
module scanline_buffer
  import scanline_pkg::*;
(
  input  logic         CLK25MHZ,
  input  logic         ck_rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [11:0]  wr_data,
  input  logic         wr_last,
  output logic [9:0]   req_y,
  output logic         req_stb,
  input  logic         next_line,
  input  logic [9:0]   next_y,
  input  logic         disp_en,
  output logic [11:0]  color_out,
`ifdef SCANLINE_UNDERRUN_CNT_EN
  output logic [15:0]  underrun_cnt,
`endif
  output logic         underrun
);

  localparam logic [9:0] HMax  = 10'(H_ACTIVE);
  localparam logic [9:0] HLast = 10'(H_ACTIVE - 1);

  fill_state_t state_q, state_d;
  logic        fill_sel_q, fill_sel_d;
  logic [9:0]  wr_ptr_q, wr_ptr_d;
  logic [9:0]  wr_cnt_q, wr_cnt_d;
  logic        disp_valid_q, disp_valid_d;
  logic [9:0]  disp_len_q, disp_len_d;
  logic [9:0]  req_y_q, req_y_d;
  logic        req_stb_q, req_stb_d;
  logic        underrun_q, underrun_d;
  logic [9:0]  rd_x_q, rd_x_d;
  logic        rd_gate_q, rd_gate_d;
  logic        rd_sel_q, rd_sel_d;

  logic   beat, final_beat, swap;
  logic   we0, we1, re0, re1;
  color_t rdata0, rdata1;

  assign wr_ready   = (state_q == FILL);
  assign beat       = wr_valid & wr_ready;
  assign final_beat = beat & (wr_last | (wr_ptr_q == HLast));
  // A final beat landing with next_line still completes the line in time.
  assign swap       = next_line & ((state_q == DONE) | final_beat);

  always_comb begin
    state_d      = state_q;
    fill_sel_d   = fill_sel_q;
    wr_ptr_d     = wr_ptr_q;
    wr_cnt_d     = wr_cnt_q;
    disp_valid_d = disp_valid_q;
    disp_len_d   = disp_len_q;
    req_y_d      = req_y_q;
    req_stb_d    = 1'b0;
    underrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d   = FILL;
        wr_ptr_d  = 10'd0;
        req_stb_d = 1'b1;
      end
      FILL: begin
        if (beat) begin
          wr_ptr_d = wr_ptr_q + 10'd1;
          if (final_beat) begin
            state_d  = DONE;
            wr_cnt_d = wr_ptr_q + 10'd1;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    if (swap) begin
      fill_sel_d   = ~fill_sel_q;
      disp_valid_d = 1'b1;
      disp_len_d   = final_beat ? (wr_ptr_q + 10'd1) : wr_cnt_q;
      state_d      = FILL;
      wr_ptr_d     = 10'd0;
      req_y_d      = next_req_y(next_y);
      req_stb_d    = 1'b1;
    end else if (next_line) begin
      underrun_d = 1'b1;
    end
  end

  // Read side: rd_x walks the display bank; the gate is registered alongside
  // the RAM read so out-of-line and invalid-bank pixels come out as 0.
  always_comb begin
    rd_x_d = rd_x_q;
    if (next_line) begin
      rd_x_d = 10'd0;
    end else if (disp_en && (rd_x_q < HMax)) begin
      rd_x_d = rd_x_q + 10'd1;
    end
    rd_gate_d = disp_en & disp_valid_q & (rd_x_q < disp_len_q);
    rd_sel_d  = ~fill_sel_q;
  end

  always_ff @(posedge CLK25MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      state_q      <= IDLE;
      fill_sel_q   <= 1'b0;
      wr_ptr_q     <= 10'd0;
      wr_cnt_q     <= 10'd0;
      disp_valid_q <= 1'b0;
      disp_len_q   <= 10'd0;
      req_y_q      <= 10'd0;
      req_stb_q    <= 1'b0;
      underrun_q   <= 1'b0;
      rd_x_q       <= 10'd0;
      rd_gate_q    <= 1'b0;
      rd_sel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_sel_q   <= fill_sel_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      disp_valid_q <= disp_valid_d;
      disp_len_q   <= disp_len_d;
      req_y_q      <= req_y_d;
      req_stb_q    <= req_stb_d;
      underrun_q   <= underrun_d;
      rd_x_q       <= rd_x_d;
      rd_gate_q    <= rd_gate_d;
      rd_sel_q     <= rd_sel_d;
    end
  end

  // Writes go to the fill bank, reads to the other one.
  assign we0 = beat & ~fill_sel_q;
  assign we1 = beat & fill_sel_q;
  assign re0 = rd_gate_d & fill_sel_q;
  assign re1 = rd_gate_d & ~fill_sel_q;

  scanline_bank_ram #(
    .Depth (H_ACTIVE),
    .Width (COLOR_W)
  ) u_bank0 (
    .clk_i   (CLK25MHZ),
    .we_i    (we0),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (re0),
    .raddr_i (rd_x_q),
    .rdata_o (rdata0)
  );

  scanline_bank_ram #(
    .Depth (H_ACTIVE),
    .Width (COLOR_W)
  ) u_bank1 (
    .clk_i   (CLK25MHZ),
    .we_i    (we1),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (re1),
    .raddr_i (rd_x_q),
    .rdata_o (rdata1)
  );

  assign color_out = rd_gate_q ? (rd_sel_q ? rdata1 : rdata0) : 12'd0;
  assign req_y     = req_y_q;
  assign req_stb   = req_stb_q;
  assign underrun  = underrun_q;

`ifdef SCANLINE_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge CLK25MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      underrun_cnt_q <= 16'd0;
    end else if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_scanline_buffer.sv
// Bench for scanline_buffer: table of whole-line scenarios plus hand-written
// sequences for underrun, final-beat-with-next_line and async reset.
// Expected pixels are queued when disp_en is driven and compared when
// color_out is due one cycle later.
module tb_scanline_buffer;

  localparam int HA = 640;

  logic        CLK25MHZ = 1'b0;
  logic        ck_rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [11:0] wr_data = '0;
  logic        wr_last = 1'b0;
  logic [9:0]  req_y;
  logic        req_stb;
  logic        next_line = 1'b0;
  logic [9:0]  next_y = '0;
  logic        disp_en = 1'b0;
  logic [11:0] color_out;
  logic        underrun;
`ifdef SCANLINE_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  scanline_buffer dut (
    .CLK25MHZ  (CLK25MHZ),
    .ck_rst    (ck_rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .req_y     (req_y),
    .req_stb   (req_stb),
    .next_line (next_line),
    .next_y    (next_y),
    .disp_en   (disp_en),
    .color_out (color_out),
`ifdef SCANLINE_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .underrun  (underrun)
  );

  always #20 CLK25MHZ = ~CLK25MHZ;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic [11:0] fill_m [HA];
  logic [11:0] disp_m [HA];
  int          fill_len_m = 0;
  int          disp_len_m = 0;
  bit          disp_valid_m = 1'b0;

  typedef struct {
    int         n_px;
    int         last_at;   // -1: no wr_last, line ends on the length cap
    int         extra;     // cycles wr_valid stays high after the line
    logic [9:0] ny;
    logic [9:0] exp_y;
    int         seed;
  } row_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int seed, input int x);
    logic [31:0] v;
    if (seed == 0) v = x;
    else v = x * 37 + seed * 401;
    return v[11:0];
  endfunction

  // Scoreboard consumer: color_out is due one edge after disp_en was sampled.
  logic        mon_de;
  logic [11:0] mon_exp;
  always @(posedge CLK25MHZ) begin
    mon_de = disp_en;
    #1;
    if (mon_de) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got color_out %0h, expected no output", color_out);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("color_out", {20'd0, color_out}, {20'd0, mon_exp});
      end
    end
  end

  initial begin
    #(40 * 30000);
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic do_reset();
    ck_rst = 1'b0;
    wr_valid = 1'b0; wr_last = 1'b0; next_line = 1'b0; disp_en = 1'b0;
    disp_valid_m = 1'b0;
    repeat (3) @(negedge CLK25MHZ);
    chk("rst_wr_ready", {31'd0, wr_ready}, 0);
    chk("rst_req_y", {22'd0, req_y}, 0);
    chk("rst_req_stb", {31'd0, req_stb}, 0);
    chk("rst_color", {20'd0, color_out}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
`ifdef SCANLINE_UNDERRUN_CNT_EN
    chk("rst_underrun_cnt", {16'd0, underrun_cnt}, 0);
`endif
    ck_rst = 1'b1;
    @(negedge CLK25MHZ);
    chk("first_wr_ready", {31'd0, wr_ready}, 1);
    chk("first_req_stb", {31'd0, req_stb}, 1);
    chk("first_req_y", {22'd0, req_y}, 0);
    @(negedge CLK25MHZ);
    chk("first_req_stb_drop", {31'd0, req_stb}, 0);
  endtask

  task automatic write_px(input int from, input int to, input int last_at, input int seed);
    int nr = 0;
    for (int x = from; x <= to; x++) begin
      if (wr_ready !== 1'b1) nr++;
      wr_valid = 1'b1;
      wr_data  = pix(seed, x);
      wr_last  = (x == last_at);
      fill_m[x] = pix(seed, x);
      @(negedge CLK25MHZ);
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    chk("wr_ready_in_fill", nr, 0);
  endtask

  task automatic model_swap();
    for (int x = 0; x < HA; x++) disp_m[x] = fill_m[x];
    disp_len_m   = fill_len_m;
    disp_valid_m = 1'b1;
  endtask

  task automatic line_pulse(input logic [9:0] ny, input logic [9:0] exp_y, input bit exp_swap);
    next_line = 1'b1;
    next_y    = ny;
    @(negedge CLK25MHZ);
    next_line = 1'b0;
    chk("pulse_req_stb", {31'd0, req_stb}, {31'd0, exp_swap});
    chk("pulse_underrun", {31'd0, underrun}, {31'd0, !exp_swap});
    chk("pulse_req_y", {22'd0, req_y}, {22'd0, exp_y});
    if (exp_swap) model_swap();
    @(negedge CLK25MHZ);
    chk("pulse_stb_drop", {31'd0, req_stb}, 0);
    chk("pulse_underrun_drop", {31'd0, underrun}, 0);
  endtask

  task automatic show();
    for (int x = 0; x < HA; x++) begin
      disp_en = 1'b1;
      exp_q.push_back((disp_valid_m && x < disp_len_m) ? disp_m[x] : 12'd0);
      @(negedge CLK25MHZ);
    end
    disp_en = 1'b0;
    @(negedge CLK25MHZ);
    chk("sb_drained", exp_q.size(), 0);
    chk("color_idle", {20'd0, color_out}, 0);
  endtask

  row_t rows[4];

  initial begin
    rows[0] = '{n_px: 640, last_at: 639, extra: 4, ny: 10'd0,   exp_y: 10'd1,   seed: 0};
    rows[1] = '{n_px: 100, last_at: 99,  extra: 0, ny: 10'd5,   exp_y: 10'd6,   seed: 1};
    rows[2] = '{n_px: 640, last_at: -1,  extra: 2, ny: 10'd479, exp_y: 10'd0,   seed: 2};
    rows[3] = '{n_px: 1,   last_at: 0,   extra: 0, ny: 10'd200, exp_y: 10'd201, seed: 3};

    do_reset();

    // Whole lines: full, short, length-capped, single pixel.
    for (int r = 0; r < 4; r++) begin
      write_px(0, rows[r].n_px - 1, rows[r].last_at, rows[r].seed);
      fill_len_m = rows[r].n_px;
      for (int e = 0; e < rows[r].extra; e++) begin
        wr_valid = 1'b1;
        wr_data  = 12'hFFF;
        chk("wr_ready_done", {31'd0, wr_ready}, 0);
        @(negedge CLK25MHZ);
      end
      wr_valid = 1'b0;
      chk("done_wr_ready", {31'd0, wr_ready}, {31'd0, (rows[r].n_px < 1)});
      line_pulse(rows[r].ny, rows[r].exp_y, 1'b1);
      show();
    end

    // Underrun: only 300 px ready; previous line repeats, req_y held.
    write_px(0, 299, -1, 5);
    line_pulse(10'd10, 10'd201, 1'b0);
`ifdef SCANLINE_UNDERRUN_CNT_EN
    chk("underrun_cnt", {16'd0, underrun_cnt}, 1);
`endif
    chk("fill_continues", {31'd0, wr_ready}, 1);
    show();

    // Finish the line; final beat coincides with next_line on the last row.
    write_px(300, 638, -1, 5);
    wr_valid  = 1'b1;
    wr_data   = pix(5, 639);
    wr_last   = 1'b1;
    fill_m[639] = pix(5, 639);
    fill_len_m  = 640;
    next_line = 1'b1;
    next_y    = 10'd479;
    @(negedge CLK25MHZ);
    wr_valid = 1'b0; wr_last = 1'b0; next_line = 1'b0;
    chk("final_swap_stb", {31'd0, req_stb}, 1);
    chk("final_swap_underrun", {31'd0, underrun}, 0);
    chk("final_swap_req_y", {22'd0, req_y}, 0);
    model_swap();
    @(negedge CLK25MHZ);
    show();

    // Asynchronous reset in the middle of a displayed line.
    write_px(0, 639, 639, 6);
    fill_len_m = 640;
    line_pulse(10'd50, 10'd51, 1'b1);
    for (int x = 0; x < 10; x++) begin
      disp_en = 1'b1;
      exp_q.push_back(disp_m[x]);
      @(negedge CLK25MHZ);
    end
    disp_en = 1'b0;
    #5;
    chk("pre_rst_color", {20'd0, color_out}, {20'd0, pix(6, 9)});
    chk("pre_rst_req_y", {22'd0, req_y}, 51);
    chk("pre_rst_wr_ready", {31'd0, wr_ready}, 1);
    ck_rst = 1'b0;
    #1;
    chk("async_wr_ready", {31'd0, wr_ready}, 0);
    chk("async_color", {20'd0, color_out}, 0);
    chk("async_req_y", {22'd0, req_y}, 0);
    chk("async_sb_empty", exp_q.size(), 0);
    do_reset();

    // Banks are invalid after reset even though the RAM still holds data.
    line_pulse(10'd7, 10'd0, 1'b0);
`ifdef SCANLINE_UNDERRUN_CNT_EN
    chk("underrun_cnt_after_rst", {16'd0, underrun_cnt}, 1);
`endif
    show();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
